// File: rtl/ssp_apb_master_if.sv
// Command/response stream and APB bus bundle for the PL022 SSP APB master.
// The master modport is the bridge's view; slave is the bench/peripheral side.
interface ssp_apb_master_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  PRDATA, PREADY,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output PRDATA, PREADY,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/ssp_apb_master.sv
// Single-outstanding APB master bridging a valid/ready command stream
// to the PL022 SSP register port, with optional wait-state timeout.
module ssp_apb_master #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input logic               PCLK,
    input logic               PRESET,
    ssp_apb_master_if.master  bus
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    logic [CW-1:0]     wait_cnt;
    logic [CW-1:0]     cnt_inc;
    logic              to_hit;

    logic              cmd_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;

    // Saturating increment so a stuck slave with TIMEOUT=0 never wraps.
    always_comb begin
        cnt_inc = (wait_cnt == {CW{1'b1}}) ? wait_cnt : wait_cnt + CW'(1);
        to_hit  = (TIMEOUT != 0) && (cnt_inc == TO_VAL);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        state     <= SETUP;
                        cmd_ready <= 1'b0;
                        psel      <= 1'b1;
                        pwrite    <= bus.cmd_write;
                        paddr     <= bus.cmd_addr;
                        pwdata    <= bus.cmd_wdata;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    // A ready slave beats a timeout landing on the same edge.
                    if (bus.PREADY || to_hit) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ~bus.PREADY;
                        rsp_rdata <= (bus.PREADY && !pwrite) ? bus.PRDATA : '0;
                        wait_cnt  <= '0;
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        pwrite    <= 1'b0;
                        paddr     <= '0;
                        pwdata    <= '0;
                    end else begin
                        wait_cnt <= cnt_inc;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.rsp_err   = rsp_err;
    assign bus.PSEL      = psel;
    assign bus.PENABLE   = penable;
    assign bus.PWRITE    = pwrite;
    assign bus.PADDR     = paddr;
    assign bus.PWDATA    = pwdata;
endmodule

// File: tb/tb_ssp_apb_master.sv
// Bench for ssp_apb_master: PL022-like register slave, transaction-level
// reference model, per-cycle output compare and randomized command traffic.
module tb_ssp_apb_master;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ssp_apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ssp_apb_master #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .PCLK  (clk),
        .PRESET(rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event expected one within budget at %0t", name, $time);
    endtask

    function automatic logic [DW-1:0] rst_val(input int a);
        case (a)
            'h003:   return 16'h0003;
            'h3F8:   return 16'h0022;
            'h3F9:   return 16'h0010;
            'h3FA:   return 16'h0004;
            'h3FC:   return 16'h000D;
            'h3FD:   return 16'h00F0;
            'h3FE:   return 16'h0005;
            'h3FF:   return 16'h00B1;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit writable(input int a);
        return (a != 'h003) && (a < 'h3F8);
    endfunction

    // PL022-like slave: PREADY rises after plan_w wait cycles in ACCESS;
    // outside a ready ACCESS the bus carries noise to catch bad sampling.
    logic [DW-1:0] slv_mem [1024];
    int            plan_w = 0;
    int            acc_cnt = 0;
    logic          junk_rdy = 1'b0;
    logic [DW-1:0] junk_data = '0;
    logic          in_acc;

    assign in_acc      = bus.PSEL && bus.PENABLE;
    assign bus.PREADY  = in_acc ? (acc_cnt >= plan_w) : junk_rdy;
    assign bus.PRDATA  = (in_acc && acc_cnt >= plan_w) ? slv_mem[bus.PADDR] : junk_data;

    always @(negedge clk) begin
        junk_rdy  <= 1'($urandom);
        junk_data <= DW'($urandom);
    end

    always @(posedge clk) begin
        if (rst) begin
            acc_cnt <= 0;
            for (int i = 0; i < 1024; i++) slv_mem[i] <= rst_val(i);
        end else if (in_acc) begin
            if (bus.PREADY) begin
                acc_cnt <= 0;
                if (bus.PWRITE && writable(int'(bus.PADDR)))
                    slv_mem[bus.PADDR] <= bus.PWDATA;
            end else begin
                acc_cnt <= acc_cnt + 1;
            end
        end else begin
            acc_cnt <= 0;
        end
    end

    // Transaction-level model: on accept, decide the whole outcome
    // (access length, error, data) and track edges elapsed since accept.
    logic [DW-1:0] exp_mem [1024];
    bit            m_on = 0;
    bit            m_busy = 0;
    int            m_t = 0;
    int            m_acc = 0;
    bit            m_w = 0;
    bit            m_err = 0;
    logic [AW-1:0] m_a = '0;
    logic [DW-1:0] m_d = '0;
    logic [DW-1:0] m_rd = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_on   = 1;
            m_busy = 0;
            for (int i = 0; i < 1024; i++) exp_mem[i] = rst_val(i);
        end else if (!m_busy) begin
            if (bus.cmd_valid) begin
                m_busy = 1;
                m_t    = 1;
                m_w    = bus.cmd_write;
                m_a    = bus.cmd_addr;
                m_d    = bus.cmd_wdata;
                m_err  = (TO != 0) && (plan_w >= TO);
                m_acc  = m_err ? TO : plan_w + 1;
                m_rd   = (m_err || m_w) ? '0 : exp_mem[m_a];
                if (!m_err && m_w && writable(int'(m_a))) exp_mem[m_a] = m_d;
            end
        end else if (m_t >= 2 + m_acc && bus.rsp_ready) begin
            m_busy = 0;
        end else begin
            m_t++;
        end
    end

    always @(negedge clk) begin : cmp
        logic [30:0] e;
        logic [30:0] a;
        bit setup_c, acc_c, resp_c, on_bus;
        if (m_on) begin
            setup_c = m_busy && (m_t == 1);
            resp_c  = m_busy && (m_t >= 2 + m_acc);
            acc_c   = m_busy && (m_t > 1) && !resp_c;
            on_bus  = setup_c || acc_c;
            e = {~m_busy, on_bus, acc_c, on_bus & m_w,
                 on_bus ? m_a : {AW{1'b0}}, on_bus ? m_d : {DW{1'b0}}, resp_c};
            a = {bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE,
                 bus.PADDR, bus.PWDATA, bus.rsp_valid};
            check("cycle_outputs", 64'(a), 64'(e));
            if (resp_c)
                check("cycle_rsp", 64'({bus.rsp_err, bus.rsp_rdata}), 64'({m_err, m_rd}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int pw, input int rdly, input bit hold, input int rst_at,
                        output logic [DW-1:0] rd, output bit er, output int lat);
        int n;
        bit acc;
        rd  = '0;
        er  = 0;
        lat = -1;
        plan_w        = pw;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        n   = 0;
        acc = 0;
        while (!acc && n < 20) begin
            acc = bus.cmd_ready;
            tick();
            n++;
        end
        if (!acc) begin
            bound_fail("accept_wait");
            bus.cmd_valid = 1'b0;
            return;
        end
        if (!hold) bus.cmd_valid = 1'b0;
        if (rst_at >= 0) begin
            repeat (rst_at) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            bus.cmd_valid = 1'b0;
            return;
        end
        n = 0;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        if (!bus.rsp_valid) begin
            bound_fail("rsp_wait");
            bus.cmd_valid = 1'b0;
            return;
        end
        lat = n;
        repeat (rdly) tick();
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got no finish expected one by %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic [AW-1:0] ad;
        bit er, w, hold;
        int lat, pw, rdly, ra;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_psel", 64'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 64'd0);
        check("rst_paddr_pwdata", 64'({bus.PADDR, bus.PWDATA}), 64'd0);
        check("rst_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'd0);

        xfer(0, 10'h003, 0, 0, 0, 0, -1, rd, er, lat);
        check("rd_sspsr", 64'(rd), 64'h0003);
        check("rd_sspsr_err", 64'(er), 64'd0);
        check("lat_nowait", 64'(lat), 64'd2);
        xfer(0, 10'h3F8, 0, 0, 0, 0, -1, rd, er, lat);
        check("rd_periphid0", 64'(rd), 64'h0022);
        xfer(0, 10'h3FF, 0, 0, 0, 0, -1, rd, er, lat);
        check("rd_cellid3", 64'(rd), 64'h00B1);

        xfer(1, 10'h001, 16'h000F, 0, 0, 0, -1, rd, er, lat);
        check("wr_rsp_zero", 64'({er, rd}), 64'd0);
        xfer(0, 10'h001, 0, 0, 0, 0, -1, rd, er, lat);
        check("rd_cr1", 64'(rd), 64'h000F);

        xfer(0, 10'h001, 0, 3, 0, 0, -1, rd, er, lat);
        check("wait3_data", 64'(rd), 64'h000F);
        check("wait3_err", 64'(er), 64'd0);
        check("wait3_lat", 64'(lat), 64'd5);

        xfer(0, 10'h003, 0, 50, 0, 0, -1, rd, er, lat);
        check("timeout_err", 64'(er), 64'd1);
        check("timeout_data", 64'(rd), 64'd0);
        check("timeout_lat", 64'(lat), 64'd5);

        xfer(1, 10'h002, 16'hBEEF, 50, 0, 0, -1, rd, er, lat);
        check("timeout_wr_err", 64'(er), 64'd1);
        xfer(0, 10'h002, 0, 0, 0, 0, -1, rd, er, lat);
        check("timeout_wr_nowrite", 64'(rd), 64'd0);

        xfer(0, 10'h3F8, 0, 0, 5, 1, -1, rd, er, lat);
        check("backpressure_data", 64'(rd), 64'h0022);

        xfer(1, 10'h001, 16'h1234, 2, 0, 0, 1, rd, er, lat);
        check("midrst_idle", 64'({bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.rsp_valid}), 64'b1000);
        xfer(0, 10'h004, 0, 0, 0, 0, -1, rd, er, lat);
        check("midrst_cpsr", 64'(rd), 64'd0);
        xfer(0, 10'h001, 0, 0, 0, 0, -1, rd, er, lat);
        check("midrst_cr1_cleared", 64'(rd), 64'd0);

        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       ad = AW'($urandom_range(0, 9));
                1:       ad = AW'('h3F8 + $urandom_range(0, 7));
                default: ad = AW'($urandom);
            endcase
            pw   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : 0;
            rdly = $urandom_range(0, 3);
            hold = ($urandom_range(0, 4) == 0);
            ra   = ($urandom_range(0, 30) == 0) ? int'($urandom_range(0, 5)) : -1;
            xfer(w, ad, DW'($urandom), pw, rdly, hold, ra, rd, er, lat);
            if (ra < 0) begin
                check("rnd_lat", 64'(lat), 64'((pw >= TO) ? 1 + TO : 2 + pw));
                check("rnd_err", 64'(er), 64'(pw >= TO));
            end
            if ($urandom_range(0, 3) == 0) tick();
        end

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
